// File: rtl/imu_pkg.sv
// Shared header constants, capture FSM encoding and a buffer address-width helper
// for the IMU frame-capture block.
package imu_pkg;

  localparam logic [7:0] IMU_HDR0 = 8'h55;
  localparam logic [7:0] IMU_HDR1 = 8'hAA;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    HDR2    = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } imu_state_e;

  function automatic int imu_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imu_frame_buf.sv
// Payload byte store: one write port, registered read that returns 0x00 when the
// caller flags the read address as out of range.
module imu_frame_buf
  import imu_pkg::*;
#(
  parameter int DEPTH = 31,
  parameter int AW    = imu_addr_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          rvalid_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[raddr_sel(waddr_i)] <= wdata_i;
    end
  end

  // Reset acts on the output register only, so the array still maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rdata_q <= '0;
    end else if (rvalid_i) begin
      rdata_q <= mem_q[raddr_sel(raddr_i)];
    end else begin
      rdata_q <= '0;
    end
  end

  function automatic logic [AW-1:0] raddr_sel(input logic [AW-1:0] a);
    return a;
  endfunction

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imu_frame_ctrl.sv
// IMU frame capture: hunts the 55 AA header, buffers and checksums the payload,
// timestamps accepted frames and holds them for host readout with an interrupt.
module imu_frame_ctrl
  import imu_pkg::*;
#(
  parameter int OSC_FREQ    = 20_000_000,
  parameter int PAYLOAD_LEN = 32,
  parameter int GAP_CYCLES  = OSC_FREQ / 1000,
  parameter int ISR_CYCLES  = OSC_FREQ / 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Rx_Vlid,
  input  logic [7:0]  Rx_Data,
  input  logic [15:0] Ms_Stamp,
  input  logic        Frame_Ack,
  input  logic [7:0]  Rd_Addr,
  output logic [7:0]  Rd_Data,
  output logic        Frame_Rdy,
  output logic [15:0] Frame_ms,
  output logic        ISR,
  output logic        Chk_Err,
  output logic        Tmo_Err,
  output logic [7:0]  Drop_Cnt
);

  localparam int DEPTH = PAYLOAD_LEN - 1;
  localparam int AW    = imu_addr_w(DEPTH);
  localparam int GW    = $clog2(GAP_CYCLES + 1);
  localparam int IW    = $clog2(ISR_CYCLES + 1);

  localparam logic [7:0]    LAST_IDX = 8'(PAYLOAD_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] ISR_LAST = IW'(ISR_CYCLES - 1);

  imu_state_e    state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    chk_q, chk_d;
  logic          drop_q, drop_d;
  logic [15:0]   stamp_q, stamp_d;
  logic [15:0]   frame_ms_q, frame_ms_d;
  logic [GW-1:0] idle_q, idle_d;
  logic [IW-1:0] isr_cnt_q, isr_cnt_d;
  logic          rdy_q, rdy_d;
  logic          isr_q, isr_d;
  logic          chk_err_q, chk_err_d;
  logic          tmo_q, tmo_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          buf_we;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    chk_d      = chk_q;
    drop_d     = drop_q;
    stamp_d    = stamp_q;
    frame_ms_d = frame_ms_q;
    idle_d     = '0;
    isr_cnt_d  = isr_cnt_q;
    rdy_d      = rdy_q;
    isr_d      = isr_q;
    chk_err_d  = 1'b0;
    tmo_d      = 1'b0;
    drop_cnt_d = drop_cnt_q;
    buf_we     = 1'b0;

    if (isr_q) begin
      if (isr_cnt_q == ISR_LAST) isr_d = 1'b0;
      else                       isr_cnt_d = isr_cnt_q + IW'(1);
    end

    unique case (state_q)
      HUNT: begin
        if (Rx_Vlid && Rx_Data == IMU_HDR0) state_d = HDR2;
      end
      HDR2: begin
        if (Rx_Vlid) begin
          if (Rx_Data == IMU_HDR1) begin
            state_d = PAYLOAD;
            stamp_d = Ms_Stamp;
            idx_d   = '0;
            sum_d   = '0;
            drop_d  = rdy_q;
          end else if (Rx_Data != IMU_HDR0) begin
            state_d = HUNT;
          end
        end
      end
      PAYLOAD: begin
        if (Rx_Vlid) begin
          if (idx_q == LAST_IDX) begin
            chk_d   = Rx_Data;
            state_d = CHECK;
          end else begin
            buf_we = !drop_q;
            sum_d  = sum_q + Rx_Data;
            idx_d  = idx_q + 8'd1;
          end
        end
      end
      CHECK: begin
        // A byte arriving here is already the start of the next header hunt.
        state_d = (Rx_Vlid && Rx_Data == IMU_HDR0) ? HDR2 : HUNT;
        if (chk_q != sum_q) begin
          chk_err_d = 1'b1;
        end else if (drop_q) begin
          if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
          rdy_d      = 1'b1;
          frame_ms_d = stamp_q;
          isr_d      = 1'b1;
          isr_cnt_d  = '0;
        end
      end
      default: state_d = HUNT;
    endcase

    if ((state_q == HDR2 || state_q == PAYLOAD) && !Rx_Vlid) begin
      if (idle_q == GAP_LAST) begin
        tmo_d   = 1'b1;
        state_d = HUNT;
      end else begin
        idle_d = idle_q + GW'(1);
      end
    end

    if (Frame_Ack && rdy_q) begin
      rdy_d = 1'b0;
      isr_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= HUNT;
      idx_q      <= '0;
      sum_q      <= '0;
      chk_q      <= '0;
      drop_q     <= 1'b0;
      stamp_q    <= '0;
      frame_ms_q <= '0;
      idle_q     <= '0;
      isr_cnt_q  <= '0;
      rdy_q      <= 1'b0;
      isr_q      <= 1'b0;
      chk_err_q  <= 1'b0;
      tmo_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      chk_q      <= chk_d;
      drop_q     <= drop_d;
      stamp_q    <= stamp_d;
      frame_ms_q <= frame_ms_d;
      idle_q     <= idle_d;
      isr_cnt_q  <= isr_cnt_d;
      rdy_q      <= rdy_d;
      isr_q      <= isr_d;
      chk_err_q  <= chk_err_d;
      tmo_q      <= tmo_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  imu_frame_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk_i    (CLK),
    .srst_i   (RST),
    .we_i     (buf_we),
    .waddr_i  (idx_q[AW-1:0]),
    .wdata_i  (Rx_Data),
    .raddr_i  (Rd_Addr[AW-1:0]),
    .rvalid_i (Rd_Addr < LAST_IDX),
    .rdata_o  (Rd_Data)
  );

  assign Frame_Rdy = rdy_q;
  assign Frame_ms  = frame_ms_q;
  assign ISR       = isr_q;
  assign Chk_Err   = chk_err_q;
  assign Tmo_Err   = tmo_q;
  assign Drop_Cnt  = drop_cnt_q;

endmodule

// File: tb/tb_imu_frame_ctrl.sv
// Randomized frame-level bench for imu_frame_ctrl against a byte-stream reference
// model of frame acceptance, drops, timestamps and buffer contents.
module tb_imu_frame_ctrl;

  localparam int NB   = 31;
  localparam int GAP  = 20000;
  localparam int ISRC = 20000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Rx_Vlid = 1'b0;
  logic [7:0]  Rx_Data = '0;
  logic [15:0] Ms_Stamp = '0;
  logic        Frame_Ack = 1'b0;
  logic [7:0]  Rd_Addr = '0;
  logic [7:0]  Rd_Data;
  logic        Frame_Rdy;
  logic [15:0] Frame_ms;
  logic        ISR;
  logic        Chk_Err;
  logic        Tmo_Err;
  logic [7:0]  Drop_Cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int chk_pulses = 0;
  int tmo_pulses = 0;

  logic [7:0]  tx_pl [NB];
  logic [7:0]  tx_chk;
  logic        ref_rdy = 1'b0;
  logic [15:0] ref_ms = '0;
  logic [7:0]  ref_buf [NB];
  int          ref_drop = 0;

  imu_frame_ctrl dut (
    .CLK(CLK), .RST(RST), .Rx_Vlid(Rx_Vlid), .Rx_Data(Rx_Data), .Ms_Stamp(Ms_Stamp),
    .Frame_Ack(Frame_Ack), .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data), .Frame_Rdy(Frame_Rdy),
    .Frame_ms(Frame_ms), .ISR(ISR), .Chk_Err(Chk_Err), .Tmo_Err(Tmo_Err), .Drop_Cnt(Drop_Cnt)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (Chk_Err === 1'b1) chk_pulses++;
    if (Tmo_Err === 1'b1) tmo_pulses++;
  end

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    Rx_Data = b;
    Rx_Vlid = 1'b1;
    tick();
    Rx_Vlid = 1'b0;
    Rx_Data = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic make_frame(input bit good, input int maxval);
    int s;
    s = 0;
    for (int i = 0; i < NB; i++) begin
      tx_pl[i] = 8'($urandom_range(0, maxval));
      s += int'(tx_pl[i]);
    end
    tx_chk = good ? 8'(s) : 8'(s + int'($urandom_range(1, 255)));
  endtask

  // Frame outcome from plain arithmetic: sum mod 256 vs checksum, then hold/drop.
  task automatic model_frame(input logic [15:0] stamp, output bit exp_err);
    int s;
    s = 0;
    for (int i = 0; i < NB; i++) s += int'(tx_pl[i]);
    exp_err = ((s % 256) != int'(tx_chk));
    if (!exp_err) begin
      if (ref_rdy) begin
        if (ref_drop < 255) ref_drop++;
      end else begin
        ref_rdy = 1'b1;
        ref_ms  = stamp;
        for (int i = 0; i < NB; i++) ref_buf[i] = tx_pl[i];
      end
    end
  endtask

  // mode 0: 55 AA, mode 1: 55 55 AA, mode 2: 55 12 AA (broken header)
  task automatic send_frame(input int mode, input logic [15:0] stamp, input bit skip55, input int maxgap);
    if (!skip55) send_byte(8'h55, int'($urandom_range(0, maxgap)));
    if (mode == 1) send_byte(8'h55, int'($urandom_range(0, maxgap)));
    else if (mode == 2) send_byte(8'h12, int'($urandom_range(0, maxgap)));
    Ms_Stamp = stamp;
    send_byte(8'hAA, 0);
    Ms_Stamp = 16'($urandom_range(0, 999));
    for (int i = 0; i < NB; i++) send_byte(tx_pl[i], int'($urandom_range(0, maxgap)));
    send_byte(tx_chk, 0);
  endtask

  task automatic do_ack();
    Frame_Ack = 1'b1;
    tick();
    Frame_Ack = 1'b0;
    ref_rdy = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    Rd_Addr = a;
    tick();
    d = Rd_Data;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    n_cmp++; if (Frame_Rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", Frame_Rdy); end
    n_cmp++; if (Frame_ms !== 16'h0) begin n_bad++; $display("FAIL reset_ms: got %h want 0000", Frame_ms); end
    n_cmp++; if (ISR !== 1'b0) begin n_bad++; $display("FAIL reset_isr: got %b want 0", ISR); end
    n_cmp++; if (Chk_Err !== 1'b0) begin n_bad++; $display("FAIL reset_chk: got %b want 0", Chk_Err); end
    n_cmp++; if (Tmo_Err !== 1'b0) begin n_bad++; $display("FAIL reset_tmo: got %b want 0", Tmo_Err); end
    n_cmp++; if (Drop_Cnt !== 8'h0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", Drop_Cnt); end
    n_cmp++; if (Rd_Data !== 8'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 00", Rd_Data); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_good_frame();
    bit e;
    int cnt;
    logic [7:0] d;
    for (int i = 0; i < NB; i++) tx_pl[i] = 8'(i + 1);
    tx_chk = 8'hF0;
    model_frame(16'h01F4, e);
    send_frame(0, 16'h01F4, 1'b0, 2);
    tick();
    n_cmp++; if (Frame_Rdy !== 1'b1) begin n_bad++; $display("FAIL good_rdy: got %b want 1", Frame_Rdy); end
    n_cmp++; if (Frame_ms !== 16'h01F4) begin n_bad++; $display("FAIL good_ms: got %h want 01f4", Frame_ms); end
    n_cmp++; if (Chk_Err !== e) begin n_bad++; $display("FAIL good_chk: got %b want %b", Chk_Err, e); end
    cnt = 0;
    while (ISR === 1'b1 && cnt < 30000) begin tick(); cnt++; end
    n_cmp++; if (cnt != ISRC) begin n_bad++; $display("FAIL good_isr_width: got %0d want %0d", cnt, ISRC); end
    n_cmp++; if (Frame_Rdy !== 1'b1) begin n_bad++; $display("FAIL good_rdy_hold: got %b want 1", Frame_Rdy); end
    rd(8'd0, d);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL good_rd0: got %h want 01", d); end
    rd(8'd30, d);
    n_cmp++; if (d !== 8'h1F) begin n_bad++; $display("FAIL good_rd30: got %h want 1f", d); end
    rd(8'd31, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL good_rd31: got %h want 00", d); end
    rd(8'd255, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL good_rd255: got %h want 00", d); end
    for (int i = 0; i < NB; i++) begin
      rd(8'(i), d);
      n_cmp++; if (d !== ref_buf[i]) begin n_bad++; $display("FAIL good_rd[%0d]: got %h want %h", i, d, ref_buf[i]); end
    end
    do_ack();
    n_cmp++; if (Frame_Rdy !== 1'b0) begin n_bad++; $display("FAIL good_ack: got %b want 0", Frame_Rdy); end
  endtask

  task automatic test_bad_checksum();
    bit e;
    int c0;
    for (int i = 0; i < NB; i++) tx_pl[i] = 8'(i + 1);
    tx_chk = 8'hF1;
    model_frame(16'h0123, e);
    c0 = chk_pulses;
    send_frame(0, 16'h0123, 1'b0, 2);
    tick();
    n_cmp++; if (Chk_Err !== e) begin n_bad++; $display("FAIL bad_chk: got %b want %b", Chk_Err, e); end
    n_cmp++; if (Frame_Rdy !== ref_rdy) begin n_bad++; $display("FAIL bad_rdy: got %b want %b", Frame_Rdy, ref_rdy); end
    n_cmp++; if (ISR !== 1'b0) begin n_bad++; $display("FAIL bad_isr: got %b want 0", ISR); end
    do_ack();
    tick();
    n_cmp++; if (chk_pulses - c0 != 1) begin n_bad++; $display("FAIL bad_chk_pulses: got %0d want 1", chk_pulses - c0); end
    n_cmp++; if (Frame_Rdy !== 1'b0) begin n_bad++; $display("FAIL bad_ack_ignored: got %b want 0", Frame_Rdy); end
  endtask

  task automatic test_occupied();
    bit e;
    logic [15:0] st;
    logic [7:0] d;
    for (int f = 0; f < 3; f++) begin
      make_frame(1'b1, 255);
      st = 16'($urandom_range(0, 999));
      model_frame(st, e);
      send_frame(0, st, 1'b0, 3);
      tick();
      n_cmp++; if (Frame_Rdy !== ref_rdy) begin n_bad++; $display("FAIL occ%0d_rdy: got %b want %b", f, Frame_Rdy, ref_rdy); end
      n_cmp++; if (Frame_ms !== ref_ms) begin n_bad++; $display("FAIL occ%0d_ms: got %h want %h", f, Frame_ms, ref_ms); end
      n_cmp++; if (Drop_Cnt !== 8'(ref_drop)) begin n_bad++; $display("FAIL occ%0d_drop: got %0d want %0d", f, Drop_Cnt, ref_drop); end
      for (int i = 0; i < NB; i++) begin
        rd(8'(i), d);
        n_cmp++; if (d !== ref_buf[i]) begin n_bad++; $display("FAIL occ%0d_rd[%0d]: got %h want %h", f, i, d, ref_buf[i]); end
      end
      if (f == 1) begin
        n_cmp++; if (Drop_Cnt !== 8'd1) begin n_bad++; $display("FAIL occ_drop_one: got %0d want 1", Drop_Cnt); end
        do_ack();
        n_cmp++; if (ISR !== 1'b0) begin n_bad++; $display("FAIL occ_ack_isr: got %b want 0", ISR); end
        n_cmp++; if (Frame_Rdy !== 1'b0) begin n_bad++; $display("FAIL occ_ack_rdy: got %b want 0", Frame_Rdy); end
      end
    end
    do_ack();
  endtask

  task automatic test_resync();
    bit e;
    int c0;
    logic [15:0] st;
    make_frame(1'b1, 255);
    st = 16'($urandom_range(0, 999));
    model_frame(st, e);
    send_frame(1, st, 1'b0, 2);
    tick();
    n_cmp++; if (Frame_Rdy !== 1'b1) begin n_bad++; $display("FAIL resync_rdy: got %b want 1", Frame_Rdy); end
    n_cmp++; if (Frame_ms !== ref_ms) begin n_bad++; $display("FAIL resync_ms: got %h want %h", Frame_ms, ref_ms); end
    do_ack();
    make_frame(1'b1, 8'h50);
    tx_chk = 8'h00;
    c0 = chk_pulses;
    send_frame(2, 16'd7, 1'b0, 2);
    tick();
    tick();
    n_cmp++; if (Frame_Rdy !== 1'b0) begin n_bad++; $display("FAIL broken_hdr_rdy: got %b want 0", Frame_Rdy); end
    n_cmp++; if (chk_pulses != c0) begin n_bad++; $display("FAIL broken_hdr_chk: got %0d pulses want 0", chk_pulses - c0); end
  endtask

  task automatic test_gap_timeout();
    bit e;
    int cnt, t0;
    logic [15:0] st;
    send_byte(8'h55, 1);
    send_byte(8'hAA, 1);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), (i == 9) ? 0 : int'($urandom_range(0, 3)));
    t0 = tmo_pulses;
    cnt = 0;
    while (Tmo_Err !== 1'b1 && cnt < 30000) begin tick(); cnt++; end
    n_cmp++; if (cnt != GAP) begin n_bad++; $display("FAIL tmo_delay: got %0d want %0d", cnt, GAP); end
    tick();
    n_cmp++; if (Tmo_Err !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse_width: got %b want 0", Tmo_Err); end
    n_cmp++; if (tmo_pulses - t0 != 1) begin n_bad++; $display("FAIL tmo_pulses: got %0d want 1", tmo_pulses - t0); end
    make_frame(1'b1, 255);
    st = 16'($urandom_range(0, 999));
    model_frame(st, e);
    send_frame(0, st, 1'b0, 3);
    tick();
    n_cmp++; if (Frame_Rdy !== 1'b1) begin n_bad++; $display("FAIL tmo_next_rdy: got %b want 1", Frame_Rdy); end
    n_cmp++; if (Frame_ms !== ref_ms) begin n_bad++; $display("FAIL tmo_next_ms: got %h want %h", Frame_ms, ref_ms); end
  endtask

  task automatic test_reset_mid();
    bit e;
    int c0;
    logic [15:0] st;
    while (!ref_rdy || ref_drop < 3) begin
      make_frame(1'b1, 255);
      st = 16'($urandom_range(0, 999));
      model_frame(st, e);
      send_frame(0, st, 1'b0, 1);
      tick();
    end
    n_cmp++; if (Drop_Cnt !== 8'd3) begin n_bad++; $display("FAIL rmid_pre_drop: got %0d want 3", Drop_Cnt); end
    n_cmp++; if (Frame_Rdy !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_rdy: got %b want 1", Frame_Rdy); end
    make_frame(1'b1, 8'h50);
    send_byte(8'h55, 0);
    send_byte(8'hAA, 0);
    for (int i = 0; i < 5; i++) send_byte(tx_pl[i], (i == 4) ? 0 : 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    ref_rdy = 1'b0; ref_drop = 0; ref_ms = '0;
    n_cmp++; if (Frame_Rdy !== 1'b0) begin n_bad++; $display("FAIL rmid_rdy: got %b want 0", Frame_Rdy); end
    n_cmp++; if (Frame_ms !== 16'h0) begin n_bad++; $display("FAIL rmid_ms: got %h want 0000", Frame_ms); end
    n_cmp++; if (ISR !== 1'b0) begin n_bad++; $display("FAIL rmid_isr: got %b want 0", ISR); end
    n_cmp++; if (Drop_Cnt !== 8'h0) begin n_bad++; $display("FAIL rmid_drop: got %0d want 0", Drop_Cnt); end
    n_cmp++; if (Rd_Data !== 8'h0) begin n_bad++; $display("FAIL rmid_rdata: got %h want 00", Rd_Data); end
    c0 = chk_pulses;
    for (int i = 5; i < NB; i++) send_byte(tx_pl[i], 1);
    send_byte(8'h3C, 0);
    tick();
    tick();
    n_cmp++; if (Frame_Rdy !== 1'b0) begin n_bad++; $display("FAIL rmid_tail_rdy: got %b want 0", Frame_Rdy); end
    n_cmp++; if (chk_pulses != c0) begin n_bad++; $display("FAIL rmid_tail_chk: got %0d pulses want 0", chk_pulses - c0); end
    make_frame(1'b1, 255);
    st = 16'($urandom_range(0, 999));
    model_frame(st, e);
    send_frame(0, st, 1'b0, 2);
    tick();
    n_cmp++; if (Frame_Rdy !== 1'b1) begin n_bad++; $display("FAIL rmid_new_rdy: got %b want 1", Frame_Rdy); end
    n_cmp++; if (Frame_ms !== ref_ms) begin n_bad++; $display("FAIL rmid_new_ms: got %h want %h", Frame_ms, ref_ms); end
  endtask

  task automatic test_back_to_back();
    bit e;
    logic [15:0] st;
    logic [7:0] d;
    if (ref_rdy) do_ack();
    for (int k = 0; k < 8; k++) begin
      make_frame($urandom_range(0, 3) != 0, 255);
      st = 16'($urandom_range(0, 999));
      model_frame(st, e);
      send_frame(0, st, k > 0, 2);
      // The next header's 0x55 lands in the CHECK cycle.
      if (k < 7) send_byte(8'h55, 0);
      else tick();
      n_cmp++; if (Frame_Rdy !== ref_rdy) begin n_bad++; $display("FAIL b2b%0d_rdy: got %b want %b", k, Frame_Rdy, ref_rdy); end
      n_cmp++; if (Frame_ms !== ref_ms) begin n_bad++; $display("FAIL b2b%0d_ms: got %h want %h", k, Frame_ms, ref_ms); end
      n_cmp++; if (Drop_Cnt !== 8'(ref_drop)) begin n_bad++; $display("FAIL b2b%0d_drop: got %0d want %0d", k, Drop_Cnt, ref_drop); end
      n_cmp++; if (Chk_Err !== e) begin n_bad++; $display("FAIL b2b%0d_chk: got %b want %b", k, Chk_Err, e); end
      n_cmp++; if (ISR !== ref_rdy) begin n_bad++; $display("FAIL b2b%0d_isr: got %b want %b", k, ISR, ref_rdy); end
      if (k < 7 && $urandom_range(0, 2) == 0) do_ack();
    end
    for (int i = 0; i < NB; i++) begin
      rd(8'(i), d);
      n_cmp++; if (d !== ref_buf[i]) begin n_bad++; $display("FAIL b2b_rd[%0d]: got %h want %h", i, d, ref_buf[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_occupied();
    test_resync();
    test_gap_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
